// File: rtl/program_mem_responder.sv
// program_mem_responder: round-robin arbiter sharing one program memory read port among fetchers.
// Optional feature: define PROGRAM_MEM_BROADCAST_EN to serve every requester whose address matches the granted read.
module program_mem_responder #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
    output logic                     mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address,
    input  logic                     mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data
);
    localparam int IDW = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;
    typedef enum logic [1:0] {IDLE, REQUESTING, RELAYING} state_t;
    state_t                     state_q, state_d;
    logic [IDW-1:0]             rr_q, rr_d, id_q, id_d, cand, gnt;
    logic                       mem_valid_q, mem_valid_d;
    logic [ADDR_BITS-1:0]       addr_q, addr_d;
    logic [NUM_CONSUMERS-1:0]   ready_q, ready_d;
    logic [DATA_BITS-1:0]       data_q [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]       data_d [NUM_CONSUMERS];
    // Scan offsets from farthest to nearest so the first requester at or after rr wins.
    always_comb begin
        gnt  = rr_q;
        cand = rr_q;
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_q) + k) % NUM_CONSUMERS);
            if (consumer_read_valid[cand]) gnt = cand;
        end
    end
    // Grant, hold the memory request until data returns, then relay it until the requester lets go.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        mem_valid_d = mem_valid_q;
        addr_d      = addr_q;
        ready_d     = ready_q;
        data_d      = data_q;
        case (state_q)
            IDLE: begin
                if (|consumer_read_valid) begin
                    id_d        = gnt;
                    addr_d      = consumer_read_address[gnt];
                    mem_valid_d = 1'b1;
                    state_d     = REQUESTING;
                end
            end
            REQUESTING: begin
                if (mem_read_ready) begin
                    mem_valid_d   = 1'b0;
                    ready_d[id_q] = 1'b1;
                    data_d[id_q]  = mem_read_data;
`ifdef PROGRAM_MEM_BROADCAST_EN
                    for (int j = 0; j < NUM_CONSUMERS; j++) begin
                        if (consumer_read_valid[j] && consumer_read_address[j] == addr_q) begin
                            ready_d[j] = 1'b1;
                            data_d[j]  = mem_read_data;
                        end
                    end
`endif
                    state_d = RELAYING;
                end
            end
            RELAYING: begin
                for (int j = 0; j < NUM_CONSUMERS; j++) begin
                    if (!consumer_read_valid[j]) ready_d[j] = 1'b0;
                end
                if (ready_d == '0) begin
                    state_d = IDLE;
                    rr_d    = (id_q == IDW'(NUM_CONSUMERS - 1)) ? '0 : id_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // State registers; reset abandons any in-flight memory read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            mem_valid_q <= 1'b0;
            addr_q      <= '0;
            ready_q     <= '0;
            for (int j = 0; j < NUM_CONSUMERS; j++) data_q[j] <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            mem_valid_q <= mem_valid_d;
            addr_q      <= addr_d;
            ready_q     <= ready_d;
            data_q      <= data_d;
        end
    end
    assign mem_read_valid      = mem_valid_q;
    assign mem_read_address    = addr_q;
    assign consumer_read_ready = ready_q;
    assign consumer_read_data  = data_q;
endmodule

// File: tb/tb_program_mem_responder.sv
// tb_program_mem_responder: scoreboard bench for program_mem_responder (honours PROGRAM_MEM_BROADCAST_EN).
module tb_program_mem_responder;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  valid;
    logic [AW-1:0] addr [N];
    logic [N-1:0]  ready;
    logic [DW-1:0] rdata [N];
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_ready;
    logic [DW-1:0] mem_read_data;
    typedef struct {int id; logic [DW-1:0] data;} exp_t;
    exp_t          exp_q [$];
    logic [AW-1:0] rd_q [$];
    exp_t          e;
    int            checks = 0;
    int            errors = 0;
    logic [N-1:0]  auto_drop, pend;
    int            hold [N];
    int            rearm [N];
    int            hcnt [N];
    int            mem_wait = 0;
    logic          mem_tie = 1'b0;
    int            wcnt = 0;
    logic          pv = 1'b0;
    logic [AW-1:0] pa = '0;
    logic [N-1:0]  v_seen = '0, r_prev = '0;
    logic          rst_seen = 1'b1;
    logic [DW-1:0] d_prev [N];

    always #5 clk = ~clk;

    program_mem_responder #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(valid), .consumer_read_address(addr),
        .consumer_read_ready(ready), .consumer_read_data(rdata),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] lookup(input logic [AW-1:0] a);
        return (a == 8'h1A) ? 16'hBEEF : {8'hC0, a};
    endfunction

    task automatic expect_rsp(input int id, input logic [DW-1:0] d);
        exp_q.push_back('{id: id, data: d});
    endtask

    // One cycle: step to just after the falling edge and let each consumer react to its ready.
    task automatic tick();
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
                valid[i] = 1'b1;
                pend[i]  = 1'b0;
            end else if (auto_drop[i] && valid[i] && ready[i]) begin
                if (hcnt[i] >= hold[i]) begin
                    valid[i] = 1'b0;
                    hcnt[i]  = 0;
                    if (rearm[i] > 0) begin
                        rearm[i]--;
                        pend[i] = 1'b1;
                    end
                end else hcnt[i]++;
            end
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || rd_q.size() != 0 || mem_read_valid || ready != 0 || valid != 0 || pend != 0) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(n < budget), 1);
    endtask

    // Program memory: responds after mem_wait cycles (or every cycle when tied high) and checks read addresses.
    always @(negedge clk) begin
        if (mem_read_valid && pv) chk("addr_hold", 32'(mem_read_address), 32'(pa));
        pv = mem_read_valid;
        pa = mem_read_address;
        if (mem_tie) begin
            mem_read_ready = 1'b1;
            mem_read_data  = lookup(mem_read_address);
        end else if (mem_read_ready || !mem_read_valid) begin
            mem_read_ready = 1'b0;
            wcnt           = 0;
        end else if (wcnt >= mem_wait) begin
            mem_read_ready = 1'b1;
            mem_read_data  = lookup(mem_read_address);
        end else wcnt++;
        if (mem_read_valid && mem_read_ready) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_read: unexpected read of %h", mem_read_address);
            end else chk("mem_addr", 32'(mem_read_address), 32'(rd_q.pop_front()));
        end
    end

    always @(posedge clk) begin
        v_seen   = valid;
        rst_seen = reset;
    end

    // Monitor: every rising ready is matched against the scoreboard; held/cleared behaviour checked each cycle.
    always @(negedge clk) begin
        if (!rst_seen) begin
            for (int i = 0; i < N; i++) begin
                if (ready[i] && !r_prev[i]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL response: unexpected ready[%0d] data %h", i, rdata[i]);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant_id", 32'(i), 32'(e.id));
                        chk("rsp_data", 32'(rdata[i]), 32'(e.data));
                    end
                end
                if (r_prev[i] && !v_seen[i]) chk("ready_clear", 32'(ready[i]), 0);
                if (r_prev[i] && v_seen[i]) chk("ready_hold", {15'd0, ready[i], rdata[i]}, {15'd0, 1'b1, d_prev[i]});
            end
        end
        r_prev = ready;
        d_prev = rdata;
    end

    initial begin
        logic       em [5];
        logic [1:0] er [5];
        em = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        er = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd2};
        reset = 1'b1;
        valid = '0;
        pend = '0;
        auto_drop = '0;
        mem_read_ready = 1'b0;
        mem_read_data = '0;
        for (int i = 0; i < N; i++) begin
            addr[i] = '0;
            hold[i] = 0;
            rearm[i] = 0;
            hcnt[i] = 0;
        end
        tick();
        tick();
        chk("rst_mem_valid", 32'(mem_read_valid), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_mem_addr", 32'(mem_read_address), 0);
        reset = 1'b0;
        tick();
        // Single fetch, 3-cycle memory wait, consumer holds valid a little after ready.
        mem_wait = 3;
        addr[2] = 8'h1A;
        auto_drop[2] = 1'b1;
        hold[2] = 2;
        expect_rsp(2, 16'hBEEF);
        rd_q.push_back(8'h1A);
        valid[2] = 1'b1;
        wait_done("single_done", 60);
        chk("single_data2", 32'(rdata[2]), 32'h0000BEEF);
        chk("single_keep0", 32'(rdata[0]), 0);
        chk("single_keep3", 32'(rdata[3]), 0);
        // Zero-wait memory: exact cycle pattern of two back-to-back grants.
        mem_tie = 1'b1;
        hold[2] = 0;
        tick();
        addr[0] = 8'h05;
        addr[1] = 8'h06;
        auto_drop[1:0] = 2'b11;
        expect_rsp(0, 16'hC005);
        expect_rsp(1, 16'hC006);
        rd_q.push_back(8'h05);
        rd_q.push_back(8'h06);
        valid[1:0] = 2'b11;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("b2b_mem_valid", 32'(mem_read_valid), 32'(em[k]));
            chk("b2b_ready", 32'(ready), 32'(er[k]));
        end
        wait_done("b2b_done", 30);
        chk("b2b_keep0", 32'(rdata[0]), 32'h0000C005);
        chk("b2b_keep2", 32'(rdata[2]), 32'h0000BEEF);
        // Consumer 1 abandons its request while memory is still busy.
        mem_tie = 1'b0;
        mem_wait = 2;
        tick();
        addr[1] = 8'h31;
        auto_drop[1] = 1'b0;
        expect_rsp(1, 16'hC031);
        rd_q.push_back(8'h31);
        valid[1] = 1'b1;
        tick();
        chk("abort_requesting", 32'(mem_read_valid), 1);
        valid[1] = 1'b0;
        wait_done("abort_done", 30);
        tick();
        chk("abort_idle_ready", 32'(ready), 0);
        chk("abort_idle_valid", 32'(mem_read_valid), 0);
        // Reset mid-REQUESTING.
        mem_wait = 10;
        addr[3] = 8'h40;
        valid[3] = 1'b1;
        tick();
        tick();
        chk("mid_mem_valid", 32'(mem_read_valid), 1);
        chk("mid_mem_addr", 32'(mem_read_address), 32'h40);
        reset = 1'b1;
        valid[3] = 1'b0;
        tick();
        tick();
        chk("rst2_mem_valid", 32'(mem_read_valid), 0);
        chk("rst2_mem_addr", 32'(mem_read_address), 0);
        chk("rst2_ready", 32'(ready), 0);
        for (int i = 0; i < N; i++) chk("rst2_data", 32'(rdata[i]), 0);
        reset = 1'b0;
        tick();
        // Round robin: everyone requests, consumer 0 comes back once.
        mem_wait = 1;
        for (int i = 0; i < N; i++) addr[i] = 8'h10 + 8'(i);
        auto_drop = '1;
        rearm[0] = 1;
        expect_rsp(0, 16'hC010);
        expect_rsp(1, 16'hC011);
        expect_rsp(2, 16'hC012);
        expect_rsp(3, 16'hC013);
        expect_rsp(0, 16'hC010);
        rd_q.push_back(8'h10);
        rd_q.push_back(8'h11);
        rd_q.push_back(8'h12);
        rd_q.push_back(8'h13);
        rd_q.push_back(8'h10);
        valid = '1;
        wait_done("rr_done", 200);
        // Shared address: merged into one read when broadcast is built in.
        mem_wait = 0;
        addr[0] = 8'h20;
        addr[1] = 8'h20;
        addr[2] = 8'h21;
        addr[3] = 8'h20;
`ifdef PROGRAM_MEM_BROADCAST_EN
        expect_rsp(0, 16'hC020);
        expect_rsp(1, 16'hC020);
        expect_rsp(3, 16'hC020);
        expect_rsp(2, 16'hC021);
        rd_q.push_back(8'h20);
        rd_q.push_back(8'h21);
`else
        expect_rsp(1, 16'hC020);
        expect_rsp(2, 16'hC021);
        expect_rsp(3, 16'hC020);
        expect_rsp(0, 16'hC020);
        rd_q.push_back(8'h20);
        rd_q.push_back(8'h21);
        rd_q.push_back(8'h20);
        rd_q.push_back(8'h20);
`endif
        valid = '1;
        wait_done("bcast_done", 200);
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/program_mem_responder.md
PROGRAM_MEM_RESPONDER -- requirements
Module: program_mem_responder

Interface
REQ-001 SHALL have parameter NUM_CONSUMERS, default 4, number of fetcher-side read ports.
REQ-002 SHALL have parameter ADDR_BITS, default 8, program memory address width.
REQ-003 SHALL have parameter DATA_BITS, default 16, instruction width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port consumer_read_valid  input  [NUM_CONSUMERS]  per-consumer request, held high until served.
REQ-007 SHALL have port consumer_read_address  input  array [NUM_CONSUMERS] of ADDR_BITS  per-consumer address.
REQ-008 SHALL have port consumer_read_ready  output reg  [NUM_CONSUMERS]  per-consumer response strobe.
REQ-009 SHALL have port consumer_read_data  output reg  array [NUM_CONSUMERS] of DATA_BITS  per-consumer returned instruction.
REQ-010 SHALL have port mem_read_valid  output reg  1  request to external program memory.
REQ-011 SHALL have port mem_read_address  output reg  ADDR_BITS  address to program memory.
REQ-012 SHALL have port mem_read_ready  input  1  program memory data valid.
REQ-013 SHALL have port mem_read_data  input  DATA_BITS  program memory read data.

Function
REQ-014 SHALL implement FSM states IDLE, REQUESTING, RELAYING; one memory transaction outstanding at most.
REQ-015 IDLE: when any consumer_read_valid bit high, SHALL grant lowest index at or after round-robin pointer rr (wrapping modulo NUM_CONSUMERS), latch grant id and its address, set mem_read_valid=1, mem_read_address=latched address, go REQUESTING.
REQ-016 REQUESTING: mem_read_valid and mem_read_address SHALL stay constant until mem_read_ready sampled high.
REQ-017 On mem_read_ready high in REQUESTING: mem_read_valid<=0, consumer_read_data[id]<=mem_read_data, consumer_read_ready[id]<=1, go RELAYING.
REQ-018 RELAYING: consumer_read_ready[id] and consumer_read_data[id] SHALL hold until consumer_read_valid[id] sampled low; then ready<=0, rr<=(id+1) mod NUM_CONSUMERS, go IDLE.
REQ-019 Latency: valid high before edge N, mem ready high before edge N+1 -> consumer_read_ready high after edge N+1 (2 cycles minimum); one IDLE cycle between consecutive grants.
REQ-020 Consumer valid dropping before completion SHALL NOT abort the memory read; ready SHALL still pulse, then clear on the following edge.
REQ-021 Requests arriving in REQUESTING or RELAYING SHALL wait; no request SHALL be dropped; starvation-free via rr.
REQ-022 consumer_read_data for non-granted consumers SHALL retain last value.
REQ-023 mem_read_ready outside REQUESTING SHALL be ignored.

Reset
REQ-024 On reset in any state, next edge: state=IDLE, rr=0, mem_read_valid=0, mem_read_address=0, all consumer_read_ready=0, all consumer_read_data=0; an in-flight memory read SHALL be abandoned.

Configuration
REQ-025 Macro PROGRAM_MEM_BROADCAST_EN SHALL select address-merge broadcast.
REQ-026 Defined: on mem_read_ready, every consumer j with consumer_read_valid[j]=1 and address equal to latched address SHALL receive data and ready=1 in the same cycle; each ready clears individually when its valid drops; IDLE entered when all served readies are low; rr advances past grant id only.
REQ-027 Not defined: only granted consumer served (REQ-017/018); no address comparators synthesized.

Verification
REQ-028 Reset: reset high 2 cycles mid-REQUESTING -> mem_read_valid=0, all readies 0, next request granted to consumer 0.
REQ-029 Single fetch: consumer 2 valid, address 0x1A, memory returns 0xBEEF after 3-cycle wait -> mem_read_address=0x1A held throughout, consumer_read_ready[2]=1 with data 0xBEEF, cleared one cycle after valid drops.
REQ-030 Round-robin: consumers 0-3 all valid continuously, addresses 0x10-0x13 -> grant order 0,1,2,3,0; no consumer served twice before others.
REQ-031 Abort: consumer 1 drops valid during REQUESTING -> ready[1] pulses exactly one cycle, FSM returns to IDLE.
REQ-032 Broadcast (macro defined): consumers 0,1,3 request 0x20, consumer 2 requests 0x21 -> one memory read of 0x20 serves 0,1,3 simultaneously; next read 0x21 serves 2. Macro undefined: four separate reads.
REQ-033 Zero-wait memory: mem_read_ready tied high -> consumer ready 2 cycles after valid, back-to-back grants 1 idle cycle apart.
